count_stream_rx: RTL and testbench



---
 rtl/count_stream_rx.sv | 127 ++++++++++++
 tb/tb_count_stream_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_stream_rx.sv
// count_stream_rx
//   Consumer for a free-running counter stream. Accepts WIDTH-bit samples over a
//   valid/ready handshake, registers the doubled sample for a downstream stage,
//   keeps the most recent even sample, and counts accepted samples (saturating).
//
// Optional feature (macro COUNT_STREAM_RX_SEQ_CHECK_EN):
//   When defined, each accepted sample after the first one following reset is
//   checked against previous+1 (mod 2^WIDTH). A gap sets the sticky seq_err.
//   When undefined, seq_err is tied low.
//
// Ports
//   clk        in   clock, posedge active
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer presents in_data
//   in_ready   out  block can accept this cycle (combinational from out_ready)
//   in_data    in   WIDTH-bit sample
//   out_valid  out  out_dbl holds an undelivered result
//   out_ready  in   sink accepts out_dbl this cycle
//   out_dbl    out  accepted sample * 2 mod 2^WIDTH
//   out_even   out  most recent accepted even sample
//   out_cnt    out  accepted-sample count, saturating at 2^CNT_W-1
//   seq_err    out  sticky sequence-gap flag

module count_stream_rx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_dbl,
  output logic [WIDTH-1:0] out_even,
  output logic [CNT_W-1:0] out_cnt,
  output logic             seq_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  // Ready when the output slot is free or is being drained this cycle; held low in reset.
  assign in_ready  = rst_n & ((state == EMPTY) | out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == FULL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; FULL & accept implies out_ready, so the slot is refilled in place.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready && !accept) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Result, even-sample copy and saturating count, updated only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_dbl  <= '0;
      out_even <= '0;
      out_cnt  <= '0;
    end else if (accept) begin
      out_dbl <= {in_data[WIDTH-2:0], 1'b0};
      if (!in_data[0]) begin
        out_even <= in_data;
      end
      if (out_cnt != CNT_MAX) begin
        out_cnt <= out_cnt + CNT_W'(1);
      end
    end
  end

`ifdef COUNT_STREAM_RX_SEQ_CHECK_EN
  logic [WIDTH-1:0] last;
  logic             first_seen;
  logic             gap;

  // The first sample after reset has no predecessor, so it is never flagged.
  assign gap = first_seen & (in_data != (last + WIDTH'(1)));

  // Sequence tracker with sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last       <= '0;
      first_seen <= 1'b0;
      seq_err    <= 1'b0;
    end else if (accept) begin
      last       <= in_data;
      first_seen <= 1'b1;
      if (gap) begin
        seq_err <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_stream_rx.sv
// Scoreboard bench for count_stream_rx: directed scenarios plus randomized traffic,
// checked against a behavioural model in the negedge monitor.
module tb_count_stream_rx;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;
  localparam longint unsigned MOD = 64'h1_0000_0000;
  localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;
`ifdef COUNT_STREAM_RX_SEQ_CHECK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_dbl;
  logic [WIDTH-1:0] out_even;
  logic [CNT_W-1:0] out_cnt;
  logic             seq_err;

  int checks = 0;
  int errors = 0;

  // Scoreboard queue of expected out_dbl values and model state
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_even = '0;
  int unsigned      m_cnt = 0;
  logic             m_seq_err = 1'b0;
  logic             m_first = 1'b0;
  logic [WIDTH-1:0] m_last = '0;

  count_stream_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_dbl   (out_dbl),
    .out_even  (out_even),
    .out_cnt   (out_cnt),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare state against model, then consume/produce scoreboard entries
  always @(negedge clk) begin
    logic             exp_rdy;
    logic [WIDTH-1:0] e;
    if (!rst_n) begin
      q.delete();
      m_even    = '0;
      m_cnt     = 0;
      m_seq_err = 1'b0;
      m_first   = 1'b0;
      m_last    = '0;
    end else begin
      exp_rdy = (q.size() == 0) || out_ready;
      chk("out_valid", out_valid, (q.size() != 0) ? 1 : 0);
      chk("in_ready", in_ready, exp_rdy ? 1 : 0);
      chk("out_even", out_even, m_even);
      chk("out_cnt", out_cnt, m_cnt);
      chk("seq_err", seq_err, m_seq_err);
      chk("out_dbl_lsb", out_dbl[0], 0);
      chk("out_even_lsb", out_even[0], 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_dbl", out_dbl, e);
        end
      end
      if (in_valid && exp_rdy) begin
        q.push_back(WIDTH'((64'(in_data) * 2) % MOD));
        if (in_data % 2 == 0) m_even = in_data;
        if (m_cnt < CNT_SAT) m_cnt++;
`ifdef COUNT_STREAM_RX_SEQ_CHECK_EN
        if (m_first && (64'(in_data) != (64'(m_last) + 1) % MOD)) m_seq_err = 1'b1;
        m_first = 1'b1;
        m_last  = in_data;
`endif
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold a sample on the input until the block takes it (bounded)
  task automatic send(input logic [WIDTH-1:0] d);
    int   n = 0;
    logic ok;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: sample %0h not accepted after %0d cycles", d, n);
    end
  endtask

  // Assert reset, check immediate clearing, then release
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_dbl", out_dbl, 0);
    chk("rst_out_even", out_even, 0);
    chk("rst_out_cnt", out_cnt, 0);
    chk("rst_seq_err", seq_err, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();

    // Counting stream 0..9 with an always-ready sink
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(WIDTH'(i));
    in_valid = 1'b0;
    chk("t1_even", out_even, 8);
    chk("t1_cnt", out_cnt, 10);
    chk("t1_seq", seq_err, 0);
    cyc();

    // Backpressure holds the result and blocks the next sample
    do_reset();
    out_ready = 1'b1;
    send(WIDTH'(5));
    out_ready = 1'b0;
    in_data   = WIDTH'(6);
    repeat (3) cyc();
    chk("t2_valid", out_valid, 1);
    chk("t2_dbl_held", out_dbl, 10);
    chk("t2_in_ready", in_ready, 0);
    chk("t2_cnt", out_cnt, 1);
    out_ready = 1'b1;
    send(WIDTH'(6));
    in_valid = 1'b0;
    chk("t2_dbl_next", out_dbl, 12);
    cyc();

    // Wrap from all-ones to zero
    do_reset();
    out_ready = 1'b1;
    send(32'hFFFF_FFFF);
    chk("t3_dbl_ff", out_dbl, 32'hFFFF_FFFE);
    send(32'h0);
    in_valid = 1'b0;
    chk("t3_dbl_0", out_dbl, 0);
    chk("t3_even", out_even, 0);
    chk("t3_seq", seq_err, 0);
    cyc();

    // Sequence gap 4 -> 6 and stickiness
    do_reset();
    out_ready = 1'b1;
    send(WIDTH'(3));
    send(WIDTH'(4));
    send(WIDTH'(6));
    chk("t4_seq_gap", seq_err, SEQ_EXP);
    send(WIDTH'(7));
    in_valid = 1'b0;
    chk("t4_seq_sticky", seq_err, SEQ_EXP);
    cyc();

    // Reset while FULL; first post-reset sample is not gap-checked
    out_ready = 1'b0;
    send(WIDTH'(20));
    in_valid = 1'b0;
    chk("t5_full", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    send(WIDTH'(100));
    in_valid = 1'b0;
    cyc();
    chk("t5_seq_first", seq_err, 0);
    chk("t5_even", out_even, 100);

    // Counter saturation
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send(WIDTH'(i + 50));
    in_valid = 1'b0;
    chk("t6_sat", out_cnt, CNT_SAT);
    cyc();
    chk("t6_sat_hold", out_cnt, CNT_SAT);

    // Randomized traffic with mostly sequential data
    do_reset();
    begin
      logic [WIDTH-1:0] ctr = WIDTH'($urandom);
      for (int i = 0; i < 400; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 15) == 0) in_data = WIDTH'($urandom);
        else                            in_data = ctr;
        @(negedge clk);
        if (in_valid && in_ready) ctr = ctr + 1;
        @(posedge clk);
        #1;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
